// File: rtl/bcd_pkg.sv
// ============================================================================
//  Module : bcd_pkg
//  Brief  : Shared types and constants for the binary-to-BCD conversion engine.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package bcd_pkg;

  // Width of one BCD digit.
  localparam int c_digit_w = 4;

  // Conversion engine states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Minimum digit count able to hold 2^nbin-1, i.e. ceil(nbin*log10(2)).
  // log10(2) is approximated as 0.30103, exact for any practical width.
  function automatic int min_bcd_digits(input int nbin);
    return (nbin * 30103 + 99999) / 100000;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_dabble_step.sv
// ============================================================================
//  Module : bcd_dabble_step
//  Brief  : One double-dabble step: add 3 to every digit >= 5, then shift the
//           whole BCD vector left by one with a new bit entering at bit 0.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bcd_dabble_step
  import bcd_pkg::*;
#(
  parameter int NUMBCDS = 5
) (
  input  logic [NUMBCDS*c_digit_w-1:0] i_bcd,
  input  logic                         i_shift_in,
  output logic [NUMBCDS*c_digit_w-1:0] o_bcd
);

  localparam int c_bcd_w = NUMBCDS * c_digit_w;

  logic [c_bcd_w-1:0] w_adj;

  // Per-digit adjust; a digit of at most 9 plus 3 stays within 4 bits.
  for (genvar k = 0; k < NUMBCDS; k++) begin : g_digit
    logic [c_digit_w-1:0] w_d;
    assign w_d = i_bcd[k*c_digit_w +: c_digit_w];
    assign w_adj[k*c_digit_w +: c_digit_w] = (w_d >= 4'd5) ? (w_d + 4'd3) : w_d;
  end

  // Shift after adjust; the top bit falls off (truncation when undersized).
  assign o_bcd = {w_adj[c_bcd_w-2:0], i_shift_in};

endmodule

`default_nettype wire

// File: rtl/bcd_conv_sched.sv
// ============================================================================
//  Module : bcd_conv_sched
//  Brief  : Shared sequential binary-to-BCD converter with a two-requester
//           round-robin front end; one double-dabble step per clock.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bcd_conv_sched
  import bcd_pkg::*;
#(
  parameter int NUMBIN  = 16,
  parameter int NUMBCDS = 5
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         req0_valid,
  input  logic [NUMBIN-1:0]            req0_bin,
  output logic                         req0_ready,
  input  logic                         req1_valid,
  input  logic [NUMBIN-1:0]            req1_bin,
  output logic                         req1_ready,
  output logic                         out_valid,
  output logic [NUMBCDS*c_digit_w-1:0] out_bcd,
  output logic                         out_id,
  input  logic                         out_ready,
  output logic                         busy
);

  localparam int c_bcd_w = NUMBCDS * c_digit_w;
  localparam int c_cnt_w = $clog2(NUMBIN + 1);

  // Undersized digit count is legal but drops upper digits; flag it at build.
  if (NUMBCDS < min_bcd_digits(NUMBIN)) begin : g_undersized
    $warning("bcd_conv_sched: NUMBCDS too small for NUMBIN, upper digits truncate");
  end

  state_t               r_state;
  state_t               w_next;
  logic                 r_last_grant;
  logic                 r_id;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [NUMBIN-1:0]    r_bin;
  logic [c_bcd_w-1:0]   r_bcd;
  logic [c_bcd_w-1:0]   w_step;
  logic                 w_grant;
  logic                 w_accept;

  // Round-robin: a lone requester wins; on a tie the one not served last wins.
  assign w_grant = (req0_valid && req1_valid) ? ~r_last_grant : req1_valid;

  bcd_dabble_step #(
    .NUMBCDS (NUMBCDS)
  ) u_step (
    .i_bcd      (r_bcd),
    .i_shift_in (r_bin[NUMBIN-1]),
    .o_bcd      (w_step)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state and handshake outputs; everything is forced quiet during reset.
  always_comb begin
    w_next     = r_state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    w_accept   = 1'b0;
    case (r_state)
      IDLE: begin
        req0_ready = !reset && !w_grant;
        req1_ready = !reset && w_grant;
        w_accept   = (req0_valid && req0_ready) || (req1_valid && req1_ready);
        if (w_accept) begin
          w_next = SHIFT;
        end
      end
      SHIFT: begin
        busy = !reset;
        if (r_cnt == c_cnt_w'(1)) begin
          w_next = DONE;
        end
      end
      DONE: begin
        busy      = !reset;
        out_valid = !reset;
        if (out_ready) begin
          w_next = IDLE;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // Datapath: capture on accept, then one adjust-and-shift step per SHIFT cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_last_grant <= 1'b1;
      r_id         <= 1'b0;
      r_cnt        <= '0;
      r_bin        <= '0;
      r_bcd        <= '0;
    end else if (w_accept) begin
      r_bin        <= w_grant ? req1_bin : req0_bin;
      r_bcd        <= '0;
      r_cnt        <= c_cnt_w'(NUMBIN);
      r_id         <= w_grant;
      r_last_grant <= w_grant;
    end else if (r_state == SHIFT) begin
      r_bcd        <= w_step;
      r_bin        <= r_bin << 1;
      r_cnt        <= r_cnt - 1'b1;
    end
  end

  // Result registers hold untouched through DONE, so they feed the outputs directly.
  assign out_bcd = reset ? '0 : r_bcd;
  assign out_id  = reset ? 1'b0 : r_id;

endmodule

`default_nettype wire

// File: tb/tb_bcd_conv_sched.sv
// ============================================================================
//  Module : tb_bcd_conv_sched
//  Brief  : Directed self-checking bench for bcd_conv_sched.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_bcd_conv_sched;

  logic        clock = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid;
  logic [15:0] req0_bin, req1_bin;
  logic        req0_ready, req1_ready;
  logic        out_valid;
  logic [19:0] out_bcd;
  logic        out_id;
  logic        out_ready;
  logic        busy;

  int n_chk = 0;
  int n_err = 0;

  bcd_conv_sched #(
    .NUMBIN  (16),
    .NUMBCDS (5)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_bin   (req0_bin),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_bin   (req1_bin),
    .req1_ready (req1_ready),
    .out_valid  (out_valid),
    .out_bcd    (out_bcd),
    .out_id     (out_id),
    .out_ready  (out_ready),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for out_valid; lat counts negedges since the accept cycle.
  task automatic wait_result(inout int lat);
    while (!out_valid && lat < 40) begin
      @(negedge clock);
      lat++;
    end
  endtask

  // Issue one request from a negedge, change the input after acceptance,
  // and check latency, digits and id with out_ready held high.
  task automatic convert(input logic id, input logic [15:0] val, input logic [15:0] alt,
                         input logic [19:0] exp, input string tag);
    int lat;
    if (id) begin req1_valid = 1'b1; req1_bin = val; end
    else    begin req0_valid = 1'b1; req0_bin = val; end
    #1;
    check({tag, "_ready"}, {31'd0, (id ? req1_ready : req0_ready)}, 32'd1);
    @(negedge clock);
    lat = 1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    if (id) req1_bin = alt; else req0_bin = alt;
    check({tag, "_busy"}, {31'd0, busy}, 32'd1);
    wait_result(lat);
    check({tag, "_lat"}, lat, 32'd17);
    check({tag, "_bcd"}, {12'd0, out_bcd}, {12'd0, exp});
    check({tag, "_id"}, {31'd0, out_id}, {31'd0, id});
    @(negedge clock);
    check({tag, "_vld_off"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int lat;
    int seen;
    reset      = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b0;
    req0_bin   = 16'd0;
    req1_bin   = 16'd0;
    out_ready  = 1'b1;

    // Reset state, with a request pending to show readies are suppressed.
    @(negedge clock);
    @(negedge clock);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_busy",  {31'd0, busy}, 32'd0);
    check("rst_rdy0",  {31'd0, req0_ready}, 32'd0);
    check("rst_rdy1",  {31'd0, req1_ready}, 32'd0);
    check("rst_bcd",   {12'd0, out_bcd}, 32'd0);
    check("rst_id",    {31'd0, out_id}, 32'd0);
    req0_valid = 1'b0;
    reset = 1'b0;
    @(negedge clock);

    // Full-scale value.
    convert(1'b0, 16'd65535, 16'd1, 20'h65535, "max");

    // Tie after a fresh reset: requester 0 first, then alternation.
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    req0_valid = 1'b1; req0_bin = 16'd1234;
    req1_valid = 1'b1; req1_bin = 16'd9876;
    #1;
    check("tie1_rdy0", {31'd0, req0_ready}, 32'd1);
    check("tie1_rdy1", {31'd0, req1_ready}, 32'd0);
    @(negedge clock);
    lat = 1;
    check("tie1_shift_rdy", {30'd0, req0_ready, req1_ready}, 32'd0);
    wait_result(lat);
    check("tie1_lat", lat, 32'd17);
    check("tie1_bcd", {12'd0, out_bcd}, 32'h01234);
    check("tie1_id",  {31'd0, out_id}, 32'd0);
    @(negedge clock);
    check("tie2_rdy0", {31'd0, req0_ready}, 32'd0);
    check("tie2_rdy1", {31'd0, req1_ready}, 32'd1);
    @(negedge clock);
    lat = 1;
    wait_result(lat);
    check("tie2_lat", lat, 32'd17);
    check("tie2_bcd", {12'd0, out_bcd}, 32'h09876);
    check("tie2_id",  {31'd0, out_id}, 32'd1);
    @(negedge clock);
    check("tie3_rdy0", {31'd0, req0_ready}, 32'd1);
    check("tie3_rdy1", {31'd0, req1_ready}, 32'd0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clock);

    // Assorted values, including zero and a late input change.
    convert(1'b1, 16'd0,    16'hFFFF, 20'h00000, "zero");
    convert(1'b0, 16'd10,   16'd3,    20'h00010, "ten");
    convert(1'b0, 16'd9999, 16'd0,    20'h09999, "n9999");
    convert(1'b0, 16'd500,  16'd777,  20'h00500, "late_chg");

    // Backpressure: DONE held for 5 cycles with both requesters waiting.
    out_ready = 1'b0;
    req0_valid = 1'b1; req0_bin = 16'd4321;
    #1;
    check("bp_rdy0", {31'd0, req0_ready}, 32'd1);
    @(negedge clock);
    lat = 1;
    req0_bin = 16'd0;
    req1_valid = 1'b1; req1_bin = 16'd1;
    wait_result(lat);
    check("bp_lat", lat, 32'd17);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", {31'd0, out_valid}, 32'd1);
      check("bp_bcd",   {12'd0, out_bcd}, 32'h04321);
      check("bp_id",    {31'd0, out_id}, 32'd0);
      check("bp_rdy",   {30'd0, req0_ready, req1_ready}, 32'd0);
      @(negedge clock);
    end
    out_ready = 1'b1;
    #1;
    check("bp_hs_rdy", {30'd0, req0_ready, req1_ready}, 32'd0);
    @(negedge clock);
    check("bp_done_valid", {31'd0, out_valid}, 32'd0);
    check("bp_done_busy",  {31'd0, busy}, 32'd0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clock);

    // Reset at shift step 8 discards the conversion.
    req0_valid = 1'b1; req0_bin = 16'd3000;
    @(negedge clock);
    req0_valid = 1'b0;
    for (int i = 1; i < 8; i++) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("mid_rst_busy",  {31'd0, busy}, 32'd0);
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid) seen++;
      @(negedge clock);
    end
    check("mid_rst_no_result", seen, 32'd0);
    convert(1'b1, 16'd42, 16'd9, 20'h00042, "after_rst");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
